// File: rtl/pipelined_dmem_responder_if.sv
// Load/store request and response bus between the CPU MEM stage and the
// data-memory responder.
//   req_valid  : request present (master -> slave)
//   req_ready  : slave can accept a request this cycle
//   req_write  : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data
//   resp_valid : one-cycle response pulse
//   resp_rdata : load data, 0 for stores
//   resp_error : misaligned access flag, valid with resp_valid
interface pipelined_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/pipelined_dmem_responder.sv
// Fixed-latency, single-outstanding-request data memory slave.
// A request accepted at edge k produces a one-cycle resp_valid pulse in the
// cycle after edge k+LATENCY. Stores commit to the array at their response
// edge, so any later load sees them without forwarding.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high; clears state, outputs and the array
//   bus   : slave side of the request/response bus
//
// state | meaning
// IDLE  | no request outstanding, ready to accept
// BUSY  | request latched, counting down the access latency
// RESP  | response pulse cycle, may accept the next request back-to-back
module pipelined_dmem_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 16384,
  parameter int IDX_W       = 14
) (
  input  logic clk,
  input  logic reset,
  pipelined_dmem_responder_if.slave bus
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             lat_write;
  logic [IDX_W-1:0] lat_idx;
  logic [31:0]      lat_wdata;
  logic             lat_err;

  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_error_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic req_ready;
  logic accept;
  logic access_now;

  // Upper address bits are deliberately ignored so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[31:IDX_W+2]};

  assign req_ready  = (state != BUSY);
  assign accept     = bus.req_valid && req_ready;
  assign access_now = (state == BUSY) && (cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (cnt == '0) state_nxt = RESP;
      RESP: state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_idx      <= '0;
      lat_wdata    <= '0;
      lat_err      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_idx   <= bus.req_addr[IDX_W+1:2];
        lat_wdata <= bus.req_wdata;
        lat_err   <= (bus.req_addr[1:0] != 2'b00);
        cnt       <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access_now) begin
        if (lat_write) begin
          mem[lat_idx] <= lat_wdata;
          resp_rdata_q <= '0;
        end else begin
          resp_rdata_q <= mem[lat_idx];
        end
        resp_error_q <= lat_err;
        resp_valid_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_pipelined_dmem_responder.sv
module tb_pipelined_dmem_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 16384;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_dmem_responder_if bus ();
  pipelined_dmem_responder_if bus1 ();

  pipelined_dmem_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH), .IDX_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  pipelined_dmem_responder #(.LATENCY(1), .DEPTH_WORDS(16), .IDX_W(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge-numbered schedule of one outstanding request.
  int          edge_n = 0;
  bit          pending = 0;
  int          resp_edge;
  bit          m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          ready_m = 1;
  bit          pulse_m = 0;
  logic [31:0] rdata_m = 0;
  logic        err_m = 0;
  logic [31:0] mem_m [int];
  bit          cmp_en = 0;

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  always @(posedge clk) begin
    edge_n++;
    pulse_m = 0;
    if (reset) begin
      mem_m.delete();
      pending = 0;
      rdata_m = 0;
      err_m   = 0;
    end else if (pending && edge_n == resp_edge) begin
      pulse_m = 1;
      pending = 0;
      err_m   = (m_addr % 4) != 0;
      if (m_write) begin
        mem_m[word_of(m_addr)] = m_wdata;
        rdata_m = 0;
      end else begin
        rdata_m = mem_m.exists(word_of(m_addr)) ? mem_m[word_of(m_addr)] : 32'h0;
      end
    end else if (ready_m && bus.req_valid) begin
      pending   = 1;
      resp_edge = edge_n + LAT;
      m_write   = bus.req_write;
      m_addr    = bus.req_addr;
      m_wdata   = bus.req_wdata;
    end
    ready_m = !pending;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check_val("model_req_ready",  {31'b0, bus.req_ready},  {31'b0, ready_m});
      check_val("model_resp_valid", {31'b0, bus.resp_valid}, {31'b0, pulse_m});
      check_val("model_resp_rdata", bus.resp_rdata, rdata_m);
      check_val("model_resp_error", {31'b0, bus.resp_error}, {31'b0, err_m});
    end
  end

  // Drive a request at a negedge and wait until it is accepted.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, output int acc);
    bit got;
    got = 0;
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.req_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      check_val("accept_timeout", 32'd0, 32'd1);
    end else begin
      acc = edge_n + 1;
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 1'b0;
    end
  endtask

  // Wait for the response of a request accepted at edge acc.
  task automatic wait_resp(input string name, input int acc, input logic [31:0] exp_rdata,
                           input logic exp_err, output int r_edge);
    bit got;
    got = 0;
    r_edge = 0;
    for (int i = 0; i < LAT + 10 && !got; i++) begin
      @(negedge clk);
      if (bus.resp_valid) got = 1;
      else check_val({name, "_busy_ready"}, {31'b0, bus.req_ready}, 32'd0);
    end
    if (!got) begin
      check_val({name, "_resp_timeout"}, 32'd0, 32'd1);
    end else begin
      r_edge = edge_n;
      check_val({name, "_latency"}, r_edge - acc, LAT);
      check_val({name, "_rdata"}, bus.resp_rdata, exp_rdata);
      check_val({name, "_error"}, {31'b0, bus.resp_error}, {31'b0, exp_err});
    end
  endtask

  task automatic xfer(input string name, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rdata, input logic exp_err);
    int acc, r;
    issue(w, a, d, 1'b0, acc);
    wait_resp(name, acc, exp_rdata, exp_err, r);
    @(negedge clk);
  endtask

  initial begin
    int acc, acc2, r1, r2;
    bit seen;
    reset = 1'b1;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = 0; bus1.req_wdata = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1;
    check_val("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check_val("reset_resp_rdata", bus.resp_rdata, 32'd0);
    check_val("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);

    // 1/2: store then loads
    xfer("st_10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer("ld_10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xfer("ld_14", 1'b0, 32'h14, 32'h0, 32'h0, 1'b0);

    // 3: back-to-back through RESP
    issue(1'b0, 32'h10, 32'h0, 1'b1, acc);
    wait_resp("b2b_ld", acc, 32'hDEADBEEF, 1'b0, r1);
    check_val("b2b_resp_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h55;
    acc2 = edge_n + 1;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    wait_resp("b2b_st", acc2, 32'h0, 1'b0, r2);
    check_val("b2b_gap", r2 - r1, 32'd5);
    @(negedge clk);

    // 4: requests during BUSY are ignored
    issue(1'b0, 32'h20, 32'h0, 1'b0, acc);
    seen = 0;
    for (int i = 0; i < LAT + 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1;
      else begin
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = 32'h34; bus.req_wdata = 32'h100 + i;
      end
    end
    check_val("busy_ign_seen", {31'b0, seen}, 32'd1);
    check_val("busy_ign_rdata", bus.resp_rdata, 32'h55);
    bus.req_write = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'h77;
    acc2 = edge_n + 1;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    wait_resp("held_st", acc2, 32'h0, 1'b0, r2);
    @(negedge clk);
    xfer("ld_34", 1'b0, 32'h34, 32'h0, 32'h0, 1'b0);
    xfer("ld_30", 1'b0, 32'h30, 32'h0, 32'h77, 1'b0);

    // 5: reset mid-BUSY discards the store
    issue(1'b1, 32'h20, 32'h1234, 1'b0, acc);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (bus.resp_valid) seen = 1;
      @(negedge clk);
    end
    check_val("rst_no_resp", {31'b0, seen}, 32'd0);
    xfer("rst_ld_20", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    xfer("rst_ld_30", 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);

    // 6: misaligned and wrapping addresses
    xfer("st_cafe", 1'b1, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
    xfer("ld_13", 1'b0, 32'h13, 32'h0, 32'hCAFEF00D, 1'b1);
    xfer("ld_wrap", 1'b0, 32'h10010, 32'h0, 32'hCAFEF00D, 1'b0);
    xfer("st_mis", 1'b1, 32'h22, 32'hABCD, 32'h0, 1'b1);
    xfer("ld_20", 1'b0, 32'h20, 32'h0, 32'hABCD, 1'b0);

    // LATENCY=1 instance
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 32'h8; bus1.req_wdata = 32'hA5;
    check_val("l1_ready_idle", {31'b0, bus1.req_ready}, 32'd1);
    @(posedge clk); #1; bus1.req_valid = 1'b0;
    @(negedge clk);
    check_val("l1_st_busy_valid", {31'b0, bus1.resp_valid}, 32'd0);
    check_val("l1_st_busy_ready", {31'b0, bus1.req_ready}, 32'd0);
    @(negedge clk);
    check_val("l1_st_valid", {31'b0, bus1.resp_valid}, 32'd1);
    check_val("l1_st_rdata", bus1.resp_rdata, 32'h0);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 32'h8;
    @(posedge clk); #1; bus1.req_valid = 1'b0;
    @(negedge clk);
    check_val("l1_ld_busy_valid", {31'b0, bus1.resp_valid}, 32'd0);
    @(negedge clk);
    check_val("l1_ld_valid", {31'b0, bus1.resp_valid}, 32'd1);
    check_val("l1_ld_rdata", bus1.resp_rdata, 32'hA5);
    @(negedge clk);
    check_val("l1_pulse_end", {31'b0, bus1.resp_valid}, 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
